// File: rtl/mc_ctrl_gen_if.sv
// rtl/mc_ctrl_gen_if.sv - multi-cycle controller bus: IR/handshake inputs and datapath control outputs
// The retired port exists only when MC_PERF_CNT_EN is defined.
interface mc_ctrl_gen_if #(
    parameter int IW = 32,
    parameter int CW = 16
);
    logic [IW-1:0] ir;
    logic          cond_ok;
    logic          mem_ack;
    logic          halt_req;
    logic          mem_rd;
    logic          mem_wr;
    logic          i_or_d;
    logic          ir_write;
    logic          pc_write;
    logic [1:0]    pc_src;
    logic          reg_write;
    logic [1:0]    wd_sel;
    logic          op2_sel;
    logic [3:0]    flag_ld;
    logic [2:0]    alu_ctrl;
    logic [4:0]    state;
    logic          busy;
    logic          fault;
`ifdef MC_PERF_CNT_EN
    logic [CW-1:0] retired;
`endif

    modport master (
        output ir, cond_ok, mem_ack, halt_req,
        input  mem_rd, mem_wr, i_or_d, ir_write, pc_write, pc_src, reg_write,
        input  wd_sel, op2_sel, flag_ld, alu_ctrl, state, busy, fault
`ifdef MC_PERF_CNT_EN
        , input retired
`endif
    );

    modport slave (
        input  ir, cond_ok, mem_ack, halt_req,
        output mem_rd, mem_wr, i_or_d, ir_write, pc_write, pc_src, reg_write,
        output wd_sel, op2_sel, flag_ld, alu_ctrl, state, busy, fault
`ifdef MC_PERF_CNT_EN
        , output retired
`endif
    );
endinterface

// File: rtl/mc_ctrl_gen.sv
// rtl/mc_ctrl_gen.sv - multi-cycle fetch/decode/execute controller with memory wait timeout
// Optional retired-instruction counter enabled by MC_PERF_CNT_EN.
module mc_ctrl_gen #(
    parameter int IW  = 32,
    parameter int TMO = 15,
    parameter int CW  = 16
) (
    input  logic           clk,
    input  logic           rst,
    mc_ctrl_gen_if.slave   bus
);
    typedef enum logic [4:0] {
        S_FETCH  = 5'd0,  S_DECODE = 5'd1,  S_D_ADDR = 5'd2,  S_D_RD  = 5'd3,
        S_D_WB   = 5'd4,  S_D_WR   = 5'd5,  S_BR     = 5'd6,  S_BRL   = 5'd7,
        S_EX     = 5'd8,  S_WB     = 5'd9,  S_FLG    = 5'd10, S_PC_INC = 5'd11,
        S_HALT   = 5'd12, S_FAULT  = 5'd13
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    state_t     r_state;
    logic [7:0] r_wait;
    logic       r_i;
    logic [2:0] r_op;

    logic w_dpi, w_dti, w_bi, w_in_wait, w_timeout;

    assign w_dpi     = (bus.ir[29:24] == 6'd0);
    assign w_dti     = (bus.ir[29:21] == 9'b010000000);
    assign w_bi      = (bus.ir[29:27] == 3'b101);
    assign w_in_wait = (r_state == S_FETCH) || (r_state == S_D_RD) || (r_state == S_D_WR);
    // An ack in the same cycle the limit is reached still wins over the timeout.
    assign w_timeout = !bus.mem_ack && (r_wait == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_wait  <= 8'd0;
            r_i     <= 1'b0;
            r_op    <= 3'd0;
        end else begin
            if (w_in_wait && !bus.mem_ack)
                r_wait <= r_wait + 8'd1;
            else
                r_wait <= 8'd0;
            case (r_state)
                S_FETCH:  if (bus.mem_ack) r_state <= S_DECODE;
                          else if (w_timeout) r_state <= S_FAULT;
                S_DECODE: begin
                    r_i  <= bus.ir[23];
                    r_op <= bus.ir[22:20];
                    if (!bus.cond_ok)  r_state <= S_PC_INC;
                    else if (w_dti)    r_state <= S_D_ADDR;
                    else if (w_bi)     r_state <= bus.ir[26] ? S_BRL : S_BR;
                    else if (w_dpi)    r_state <= S_EX;
                    else               r_state <= S_FAULT;
                end
                // OP[0] and the load/store L bit are the same instruction bit.
                S_D_ADDR: r_state <= r_op[0] ? S_D_RD : S_D_WR;
                S_D_RD:   if (bus.mem_ack) r_state <= S_D_WB;
                          else if (w_timeout) r_state <= S_FAULT;
                S_D_WB:   r_state <= S_PC_INC;
                S_D_WR:   if (bus.mem_ack) r_state <= S_PC_INC;
                          else if (w_timeout) r_state <= S_FAULT;
                S_EX:     r_state <= (r_op == 3'd5 || r_op == 3'd6) ? S_FLG : S_WB;
                S_WB, S_FLG: r_state <= S_PC_INC;
                S_BR, S_BRL, S_PC_INC: r_state <= bus.halt_req ? S_HALT : S_FETCH;
                S_HALT:   if (!bus.halt_req) r_state <= S_FETCH;
                S_FAULT:  r_state <= S_FAULT;
                default:  r_state <= S_FAULT;
            endcase
        end
    end

`ifdef MC_PERF_CNT_EN
    logic [CW-1:0] r_retired;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_retired <= '0;
        else if (r_state == S_PC_INC || r_state == S_BR || r_state == S_BRL)
            r_retired <= r_retired + 1'b1;
    end
    assign bus.retired = r_retired;
`endif

    logic       w_mem_rd, w_mem_wr, w_i_or_d, w_ir_write, w_pc_write, w_reg_write, w_op2_sel;
    logic [1:0] w_pc_src, w_wd_sel;
    logic [3:0] w_flag_ld;
    logic [2:0] w_alu_ctrl, w_alu_map;
    logic [3:0] w_flag_map;

    always_comb begin
        case (r_op)
            3'd0:             w_alu_map = 3'd0;
            3'd1, 3'd2, 3'd6: w_alu_map = 3'd1;
            3'd3, 3'd5:       w_alu_map = 3'd2;
            3'd4:             w_alu_map = 3'd3;
            default:          w_alu_map = 3'd4;
        endcase
        w_flag_map = (r_op == 3'd0 || r_op == 3'd1 || r_op == 3'd2 || r_op == 3'd6)
                     ? 4'b1111 : 4'b0110;
    end

    always_comb begin
        w_mem_rd    = 1'b0;
        w_mem_wr    = 1'b0;
        w_i_or_d    = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_pc_src    = 2'd0;
        w_reg_write = 1'b0;
        w_wd_sel    = 2'd0;
        w_op2_sel   = 1'b0;
        w_flag_ld   = 4'd0;
        w_alu_ctrl  = 3'd0;
        case (r_state)
            S_FETCH: begin
                // Held off while reset is asserted so no fetch is issued from reset.
                w_mem_rd   = !rst;
                w_ir_write = !rst && bus.mem_ack;
            end
            S_D_ADDR: w_op2_sel = 1'b1;
            S_D_RD: begin
                w_mem_rd = 1'b1;
                w_i_or_d = 1'b1;
            end
            S_D_WB: begin
                w_reg_write = 1'b1;
                w_wd_sel    = 2'd1;
            end
            S_D_WR: begin
                w_mem_wr = 1'b1;
                w_i_or_d = 1'b1;
            end
            S_EX: begin
                w_op2_sel  = r_i;
                w_alu_ctrl = w_alu_map;
            end
            S_WB, S_FLG: begin
                w_reg_write = (r_state == S_WB);
                w_op2_sel   = r_i;
                w_alu_ctrl  = w_alu_map;
                w_flag_ld   = w_flag_map;
            end
            S_BR, S_BRL: begin
                w_pc_write  = 1'b1;
                w_pc_src    = 2'd1;
                w_reg_write = (r_state == S_BRL);
                w_wd_sel    = (r_state == S_BRL) ? 2'd2 : 2'd0;
            end
            S_PC_INC: w_pc_write = 1'b1;
            default: ;
        endcase
    end

    assign bus.mem_rd    = w_mem_rd;
    assign bus.mem_wr    = w_mem_wr;
    assign bus.i_or_d    = w_i_or_d;
    assign bus.ir_write  = w_ir_write;
    assign bus.pc_write  = w_pc_write;
    assign bus.pc_src    = w_pc_src;
    assign bus.reg_write = w_reg_write;
    assign bus.wd_sel    = w_wd_sel;
    assign bus.op2_sel   = w_op2_sel;
    assign bus.flag_ld   = w_flag_ld;
    assign bus.alu_ctrl  = w_alu_ctrl;
    assign bus.state     = r_state;
    assign bus.busy      = (r_state != S_HALT) && (r_state != S_FAULT);
    assign bus.fault     = (r_state == S_FAULT);
endmodule
